// File: rtl/dmem_access_unit.sv
// dmem_access_unit: bridges the single-cycle CPU's data-memory port to a
// handshaked, word-aligned multi-cycle data memory with byte enables.
// Handles lane steering, sign/zero extension, alignment checks and stalls
// the CPU until each access completes.
// Optional build macro: DMEM_TIMEOUT_EN (abort an access after TIMEOUT
// cycles without mem_ack, reporting cpu_err).
module dmem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;

  // Request attributes needed after the request edge to shape the load result.
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [1:0]  lat_off;

  logic        illegal;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] ld_ext;
  logic        ack_hit;
  logic        tmo;

  // mem_ack only counts while a request is actually outstanding.
  assign ack_hit = mem_req & mem_ack;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counts ACCESS cycles without an ack; sits at zero outside ACCESS so it
  // is clear on every entry.
  always_ff @(posedge clk) begin
    if (reset || state != ACCESS) wait_cnt <= 8'd0;
    else if (!mem_ack)            wait_cnt <= wait_cnt + 8'd1;
  end

  assign tmo = (state == ACCESS) && !mem_ack && (wait_cnt == 8'(TIMEOUT - 1));
`else
  // No abort path in this build; ACCESS waits for the ack indefinitely.
  assign tmo = 1'b0 && (TIMEOUT != 0);
`endif

  // Stall while a request waits to be accepted and while memory is busy.
  assign cpu_stall = ((state == IDLE) && cpu_req) || (state == ACCESS);

  // Legality check, byte enables and lane-replicated store data.
  always_comb begin
    illegal   = 1'b0;
    be_nxt    = 4'b1111;
    wdata_nxt = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        be_nxt    = 4'b0001 << cpu_addr[1:0];
        wdata_nxt = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        illegal   = cpu_addr[0];
        be_nxt    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{cpu_wdata[15:0]}};
      end
      2'b10: begin
        illegal   = (cpu_addr[1:0] != 2'b00);
      end
      default: begin
        illegal   = 1'b1;
      end
    endcase
  end

  // Load lane selection and extension from the latched offset/size.
  always_comb begin
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    ld_b   = mem_rdata[{lat_off, 3'b000} +: 8];
    ld_h   = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext = mem_rdata;
    case (lat_size)
      2'b00:   ld_ext = {{24{~lat_uns & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{~lat_uns & ld_h[15]}}, ld_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; RESP always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = illegal ? RESP : ACCESS;
      ACCESS:  if (ack_hit || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered CPU/memory outputs; done/err are one-cycle pulses aligned
  // with RESP, everything else holds until explicitly changed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata <= 32'd0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      lat_size  <= 2'd0;
      lat_uns   <= 1'b0;
      lat_off   <= 2'd0;
    end else begin
      cpu_done <= (state_nxt == RESP);
      cpu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (illegal) begin
              cpu_err   <= 1'b1;
              cpu_rdata <= 32'd0;
            end else begin
              lat_size  <= cpu_size;
              lat_uns   <= cpu_unsigned;
              lat_off   <= cpu_addr[1:0];
              mem_req   <= 1'b1;
              mem_we    <= cpu_we;
              mem_be    <= be_nxt;
              mem_addr  <= {cpu_addr[31:2], 2'b00};
              mem_wdata <= wdata_nxt;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            mem_req <= 1'b0;
            mem_be  <= 4'd0;
            if (!mem_we) cpu_rdata <= ld_ext;
          end else if (tmo) begin
            mem_req <= 1'b0;
            mem_be  <= 4'd0;
            cpu_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: the driver pushes expected CPU
// responses and expected memory requests into queues; a memory responder
// and a completion monitor pop and compare independently.
// Built with DMEM_TIMEOUT_EN, the last vector expects an abort after TIMEOUT=4.
module tb_dmem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_unsigned;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_done, cpu_err;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .cpu_err(cpu_err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          start;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] word;
    int          waits;
    bit          ack;
  } mem_exp_t;

  cpu_exp_t exp_q[$];
  mem_exp_t mem_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Completion monitor: every cpu_done must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && cpu_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        cpu_exp_t e;
        e = exp_q.pop_front();
        chk("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
        chk("cpu_rdata", cpu_rdata, e.rdata);
        chk("latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  // Memory responder: checks each request and acks after the given waits.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset && mem_req) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
          while (mem_req) @(negedge clk);
        end else begin
          mem_exp_t m;
          m = mem_q.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          mem_rdata = m.word;
          if (m.ack) begin
            repeat (m.waits) @(negedge clk);
            mem_ack = 1'b1;
            @(posedge clk);
            #1 mem_ack = 1'b0;
            @(negedge clk);
            chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
            chk("mem_be_drop", {28'd0, mem_be}, 32'd0);
          end else begin
            int hi;
            hi = 0;
            while (mem_req && hi < 200) begin
              hi++;
              @(negedge clk);
            end
            chk("timeout_cycles", 32'(hi), 32'(TMO));
          end
        end
      end
    end
  end

  // Issue one request, queue its expectations, and hold it until cpu_done.
  task automatic run(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] word, input int waits, input bit ack,
                     input bit mem, input logic [3:0] be, input logic [31:0] mwdata,
                     input logic [31:0] rdata, input logic err, input int lat);
    cpu_exp_t e;
    mem_exp_t m;
    bit       done;
    @(posedge clk);
    #1;
    cpu_we = we; cpu_size = size; cpu_unsigned = uns;
    cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    e.rdata = rdata; e.err = err; e.lat = lat; e.start = cyc;
    exp_q.push_back(e);
    if (mem) begin
      m.we = we; m.addr = {addr[31:2], 2'b00}; m.be = be; m.wdata = mwdata;
      m.word = word; m.waits = waits; m.ack = ack;
      mem_q.push_back(m);
    end
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (cpu_done) begin
        chk("stall_in_resp", {31'd0, cpu_stall}, 32'd0);
        done = 1;
      end else begin
        chk("stall_busy", {31'd0, cpu_stall}, 32'd1);
      end
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_cpu_done"}, {31'd0, cpu_done}, 32'd0);
    chk({tag, "_cpu_err"}, {31'd0, cpu_err}, 32'd0);
    chk({tag, "_cpu_stall"}, {31'd0, cpu_stall}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b10;
    cpu_unsigned = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_state("rst");

    //   we size uns addr         wdata         word          w  ack mem be       mwdata        rdata         err lat
    run(0, 2'b10, 0, 32'h06,  32'h0,        32'h0,        0, 1, 0, 4'h0, 32'h0,        32'h0,        1, 1);
    run(0, 2'b01, 0, 32'h05,  32'h0,        32'h0,        0, 1, 0, 4'h0, 32'h0,        32'h0,        1, 1);
    run(1, 2'b11, 0, 32'h08,  32'h55,       32'h0,        0, 1, 0, 4'h0, 32'h0,        32'h0,        1, 1);
    run(0, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h87654321, 2, 1, 1, 4'hF, 32'h0,        32'h87654321, 0, 4);
    run(0, 2'b00, 0, 32'h13,  32'h0,        32'h80AABBCC, 0, 1, 1, 4'h8, 32'h0,        32'hFFFFFF80, 0, 2);
    run(0, 2'b00, 1, 32'h13,  32'h0,        32'h80AABBCC, 1, 1, 1, 4'h8, 32'h0,        32'h00000080, 0, 3);
    run(1, 2'b01, 0, 32'h22,  32'h1234ABCD, 32'h0,        1, 1, 1, 4'hC, 32'hABCDABCD, 32'h00000080, 0, 3);
    run(1, 2'b00, 0, 32'h01,  32'h0000005A, 32'h0,        0, 1, 1, 4'h2, 32'h5A5A5A5A, 32'h00000080, 0, 2);
    run(0, 2'b01, 0, 32'h02,  32'h0,        32'h80017FFF, 0, 1, 1, 4'hC, 32'h0,        32'hFFFF8001, 0, 2);
    run(0, 2'b01, 1, 32'h00,  32'h0,        32'h80017FFF, 3, 1, 1, 4'h3, 32'h0,        32'h00007FFF, 0, 5);
    run(0, 2'b00, 0, 32'h01,  32'h0,        32'h0000F000, 0, 1, 1, 4'h2, 32'h0,        32'hFFFFFFF0, 0, 2);
    run(1, 2'b10, 0, 32'h40,  32'hCAFEF00D, 32'h0,        0, 1, 1, 4'hF, 32'hCAFEF00D, 32'hFFFFFFF0, 0, 2);

    // Reset in cycle 2 of a load whose ack arrives in cycle 3.
    begin
      mem_exp_t m;
      @(posedge clk);
      #1;
      cpu_we = 0; cpu_size = 2'b10; cpu_unsigned = 0;
      cpu_addr = 32'h30; cpu_wdata = 32'h0; cpu_req = 1'b1;
      m.we = 0; m.addr = 32'h30; m.be = 4'hF; m.wdata = 32'h0;
      m.word = 32'h13572468; m.waits = 2; m.ack = 1;
      mem_q.push_back(m);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 reset = 1'b1; cpu_req = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_reset_state("midrst");
      repeat (4) @(negedge clk);
      chk("midrst_idle_req", {31'd0, mem_req}, 32'd0);
    end

    run(1, 2'b01, 0, 32'h03,  32'h77,       32'h0,        0, 1, 0, 4'h0, 32'h0,        32'h0,        1, 1);
`ifdef DMEM_TIMEOUT_EN
    run(0, 2'b10, 0, 32'h100, 32'h0,        32'h11223344, 0, 0, 1, 4'hF, 32'h0,        32'h0,        1, TMO + 1);
`else
    run(0, 2'b10, 0, 32'h100, 32'h0,        32'h11223344, 110, 1, 1, 4'hF, 32'h0,      32'h11223344, 0, 112);
`endif

    repeat (4) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
